// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch input/timebase block.
package stopwatch_pkg;

    // Debouncer state: waiting, arming a press, pressed, arming a release
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HELD = 2'd2,
        REL  = 2'd3
    } db_state_e;

    localparam int unsigned DB_CYCLES_DEF = 1_000_000;
    localparam int unsigned CNT_DIV_DEF   = 1_000_000;
    localparam int unsigned DISP_DIV_DEF  = 100_000;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a press/release debounce FSM.
// press_c is the combinational acceptance strobe; the parent registers it.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press_c,
    output logic level
);

    localparam int unsigned CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    db_state_e     state;
    db_state_e     state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          level_next;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // State, stability counter and debounced level registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
        end
    end

    // Next state: a press or release is accepted after DB_CYCLES stable samples
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (sync_b) begin
                    state_next = ARM;
                    cnt_next   = '0;
                end
            end
            ARM: begin
                if (!sync_b) begin
                    state_next = IDLE;
                end else if (cnt == LAST) begin
                    state_next = HELD;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            HELD: begin
                if (!sync_b) begin
                    state_next = REL;
                    cnt_next   = '0;
                end
            end
            REL: begin
                if (sync_b) begin
                    state_next = HELD;
                end else if (cnt == LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs: press strobe on the ARM->HELD transition, level high while pressed
    always_comb begin
        press_c    = 1'b0;
        level_next = 1'b0;
        if (state == ARM && sync_b && cnt == LAST) begin
            press_c = 1'b1;
        end
        if (state_next == HELD || state_next == REL) begin
            level_next = 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_input_timebase.sv
// Button conditioning plus count and display timebases for the stopwatch.
module stopwatch_input_timebase
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_DIV   = CNT_DIV_DEF,
    parameter int unsigned DISP_DIV  = DISP_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_r_raw,
    input  logic       btn_p_raw,
    output logic       r_pulse,
    output logic       p_pulse,
    output logic       r_level,
    output logic       cnt_tick,
    output logic       disp_tick,
    output logic [1:0] disp_sel
);

    localparam int unsigned CNTW  = cnt_width(CNT_DIV);
    localparam int unsigned DISPW = cnt_width(DISP_DIV);
    localparam logic [CNTW-1:0]  CNT_LAST  = CNTW'(CNT_DIV - 1);
    localparam logic [DISPW-1:0] DISP_LAST = DISPW'(DISP_DIV - 1);

    logic             r_press_c;
    logic             p_press_c;
    logic             unused_p_level;
    logic [CNTW-1:0]  cnt_q;
    logic [CNTW-1:0]  cnt_next;
    logic [DISPW-1:0] disp_q;
    logic [DISPW-1:0] disp_next;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (
        .clk     (clk),
        .rst     (rst),
        .raw     (btn_r_raw),
        .press_c (r_press_c),
        .level   (r_level)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_p (
        .clk     (clk),
        .rst     (rst),
        .raw     (btn_p_raw),
        .press_c (p_press_c),
        .level   (unused_p_level)
    );

    // Prescaler next values; the count prescaler restarts after any button pulse
    always_comb begin
        cnt_next  = '0;
        disp_next = '0;
        if (!(r_pulse || p_pulse) && cnt_q != CNT_LAST) begin
            cnt_next = cnt_q + CNTW'(1);
        end
        if (disp_q != DISP_LAST) begin
            disp_next = disp_q + DISPW'(1);
        end
    end

    // Registered pulses (R wins a tie), prescalers, ticks and scan index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse   <= 1'b0;
            p_pulse   <= 1'b0;
            cnt_q     <= '0;
            cnt_tick  <= 1'b0;
            disp_q    <= '0;
            disp_tick <= 1'b0;
            disp_sel  <= 2'd0;
        end else begin
            r_pulse   <= r_press_c;
            p_pulse   <= p_press_c & ~r_press_c;
            cnt_q     <= cnt_next;
            cnt_tick  <= (cnt_next == CNT_LAST);
            disp_q    <= disp_next;
            disp_tick <= (disp_next == DISP_LAST);
            disp_sel  <= disp_sel + 2'(disp_tick);
        end
    end

endmodule

// File: tb/tb_stopwatch_input_timebase.sv
// Directed bench with a cycle-level behavioural model of the input/timebase block.
module tb_stopwatch_input_timebase;

    localparam int DB = 4;
    localparam int CD = 10;
    localparam int DD = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_r_raw = 1'b0;
    logic       btn_p_raw = 1'b0;
    logic       r_pulse;
    logic       p_pulse;
    logic       r_level;
    logic       cnt_tick;
    logic       disp_tick;
    logic [1:0] disp_sel;

    stopwatch_input_timebase #(
        .DB_CYCLES (DB),
        .CNT_DIV   (CD),
        .DISP_DIV  (DD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_r_raw (btn_r_raw),
        .btn_p_raw (btn_p_raw),
        .r_pulse   (r_pulse),
        .p_pulse   (p_pulse),
        .r_level   (r_level),
        .cnt_tick  (cnt_tick),
        .disp_tick (disp_tick),
        .disp_sel  (disp_sel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int r_cnt = 0;
    int p_cnt = 0;

    // Model state: index 0 = R button, 1 = P button
    int s1 [2];
    int s2 [2];
    int last_v [2];
    int run [2];
    int lvl [2];
    int pul [2];
    int e_r_pulse = 0, e_p_pulse = 0, e_r_level = 0, e_cnt_tick = 0, e_disp_tick = 0;
    int m_cnt = 0, m_dcnt = 0, m_sel = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // A button is accepted (or released) once its synchronized value has been
    // identical for DB+1 consecutive edges while differing from the debounced level.
    task automatic model_edge();
        int prev_pulse;
        int prev_dt;
        int raw [2];
        prev_pulse = e_r_pulse | e_p_pulse;
        prev_dt    = e_disp_tick;
        raw[0] = int'(btn_r_raw);
        raw[1] = int'(btn_p_raw);
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                s1[b] = 0; s2[b] = 0; last_v[b] = 0; run[b] = 0; lvl[b] = 0; pul[b] = 0;
            end
            e_r_pulse = 0; e_p_pulse = 0; e_r_level = 0; e_cnt_tick = 0; e_disp_tick = 0;
            m_cnt = 0; m_dcnt = 0; m_sel = 0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                int sync;
                sync = s2[b];
                if (sync == last_v[b]) run[b]++;
                else begin
                    last_v[b] = sync;
                    run[b] = 1;
                end
                pul[b] = 0;
                if (lvl[b] == 0 && sync == 1 && run[b] == DB + 1) begin
                    lvl[b] = 1;
                    pul[b] = 1;
                end else if (lvl[b] == 1 && sync == 0 && run[b] == DB + 1) begin
                    lvl[b] = 0;
                end
                s2[b] = s1[b];
                s1[b] = raw[b];
            end
            e_r_pulse = pul[0];
            e_p_pulse = (pul[1] == 1 && pul[0] == 0) ? 1 : 0;
            e_r_level = lvl[0];
            m_cnt = (prev_pulse != 0) ? 0 : (m_cnt + 1) % CD;
            e_cnt_tick = (m_cnt == CD - 1) ? 1 : 0;
            if (prev_dt != 0) m_sel = (m_sel + 1) % 4;
            m_dcnt = (m_dcnt + 1) % DD;
            e_disp_tick = (m_dcnt == DD - 1) ? 1 : 0;
        end
    endtask

    // One clock: advance the model at the edge, compare every output just after it
    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("r_pulse", int'(r_pulse), e_r_pulse);
        check("p_pulse", int'(p_pulse), e_p_pulse);
        check("r_level", int'(r_level), e_r_level);
        check("cnt_tick", int'(cnt_tick), e_cnt_tick);
        check("disp_tick", int'(disp_tick), e_disp_tick);
        check("disp_sel", int'(disp_sel), m_sel);
        if (r_pulse) r_cnt++;
        if (p_pulse) p_cnt++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        // Reset, then free-running ticks
        run_to(3);
        rst = 1'b0;
        check("rst_outputs", int'({r_pulse, p_pulse, r_level, cnt_tick, disp_tick, disp_sel}), 0);
        run_to(7);
        check("first_disp_tick", int'(disp_tick), 1);
        run_to(8);
        check("disp_sel_1", int'(disp_sel), 1);

        // Clean P press first sampled at edge 10
        run_to(9);
        btn_p_raw = 1'b1;
        run_to(12);
        check("first_cnt_tick", int'(cnt_tick), 1);
        run_to(15);
        check("p_pulse_early", int'(p_pulse), 0);
        run_to(16);
        check("p_pulse_edge16", int'(p_pulse), 1);
        check("r_pulse_edge16", int'(r_pulse), 0);
        run_to(22);
        check("cnt_tick_restart_gap", int'(cnt_tick), 0);
        run_to(23);
        check("disp_sel_wrap", int'(disp_sel), 0);
        run_to(26);
        check("cnt_tick_after_start", int'(cnt_tick), 1);
        run_to(59);
        btn_p_raw = 1'b0;
        run_to(80);
        check("clean_p_count", p_cnt, 1);
        check("clean_r_count", r_cnt, 0);

        // Bouncing R, then steady high from cycle 100
        r_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            btn_r_raw = ((i / 2) % 2 == 0);
            step();
        end
        btn_r_raw = 1'b1;
        run_to(106);
        check("bounce_level_before", int'(r_level), 0);
        run_to(107);
        check("bounce_r_pulse", int'(r_pulse), 1);
        check("bounce_r_level", int'(r_level), 1);
        run_to(120);
        check("bounce_r_count", r_cnt, 1);

        // Short release glitch, then a real release
        btn_r_raw = 1'b0;
        run_to(123);
        btn_r_raw = 1'b1;
        run_to(140);
        check("glitch_level_held", int'(r_level), 1);
        check("glitch_r_count", r_cnt, 1);
        btn_r_raw = 1'b0;
        run_to(146);
        check("release_level_before", int'(r_level), 1);
        run_to(147);
        check("release_level_drop", int'(r_level), 0);
        run_to(160);

        // Simultaneous R and P
        r_cnt = 0;
        p_cnt = 0;
        btn_r_raw = 1'b1;
        btn_p_raw = 1'b1;
        run_to(167);
        check("tie_r_pulse", int'(r_pulse), 1);
        check("tie_p_masked", int'(p_pulse), 0);
        run_to(176);
        check("tie_cnt_tick_early", int'(cnt_tick), 0);
        run_to(177);
        check("tie_cnt_tick", int'(cnt_tick), 1);
        run_to(190);
        check("tie_p_count", p_cnt, 0);
        check("tie_r_count", r_cnt, 1);
        btn_r_raw = 1'b0;
        btn_p_raw = 1'b0;
        run_to(210);

        // Reset while P is arming
        p_cnt = 0;
        btn_p_raw = 1'b1;
        run_to(214);
        rst = 1'b1;
        run_to(216);
        rst = 1'b0;
        run_to(222);
        check("abort_p_count", p_cnt, 0);
        run_to(223);
        check("rearm_p_pulse", int'(p_pulse), 1);
        run_to(240);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_input_timebase.md
STOPWATCH_INPUT_TIMEBASE -- requirements
Module: stopwatch_input_timebase

Interface
REQ-001 Parameter DB_CYCLES, default 1_000_000, number of consecutive stable synchronized samples required to accept a button edge (10 ms at 100 MHz).
REQ-002 Parameter CNT_DIV, default 1_000_000, clk cycles per count tick (100 Hz, hundredths of a second).
REQ-003 Parameter DISP_DIV, default 100_000, clk cycles per display tick (1 kHz digit refresh).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 btn_r_raw  input  1  asynchronous, bouncing reset/clear pushbutton.
REQ-007 btn_p_raw  input  1  asynchronous, bouncing start/pause pushbutton.
REQ-008 r_pulse  output  1  one-cycle pulse on each accepted R press.
REQ-009 p_pulse  output  1  one-cycle pulse on each accepted P press.
REQ-010 r_level  output  1  debounced R level, high from the accepted press until the accepted release.
REQ-011 cnt_tick  output  1  one-cycle count enable every CNT_DIV cycles, consumed by the counter stage.
REQ-012 disp_tick  output  1  one-cycle enable every DISP_DIV cycles.
REQ-013 disp_sel  output  2  digit-scan index 0..3, consumed by the display multiplexer.

Function
REQ-014 Each raw button SHALL pass through a 2-flop synchronizer reset to 0; only the second flop's output (sync) feeds the debouncer.
REQ-015 Each debouncer SHALL be a 4-state FSM: IDLE, ARM, HELD, REL, plus a stability counter of width $clog2(DB_CYCLES).
REQ-016 IDLE: sync=1 -> ARM with counter cleared; otherwise stay.
REQ-017 ARM: sync=0 -> IDLE; counter reaching DB_CYCLES-1 with sync=1 -> HELD and press pulse asserted for exactly one cycle; otherwise increment.
REQ-018 HELD: sync=0 -> REL with counter cleared; otherwise stay, with no further pulses while held.
REQ-019 REL: sync=1 -> HELD with no pulse; counter reaching DB_CYCLES-1 with sync=0 -> IDLE; otherwise increment.
REQ-020 The debounced level SHALL be 1 exactly in HELD and REL.
REQ-021 Press latency: raw first sampled 1 at edge k and held steady -> pulse high in the cycle following edge k+2+DB_CYCLES.
REQ-022 Glitches shorter than DB_CYCLES SHALL produce no pulse and no level change.
REQ-023 Simultaneous accepted R and P presses in the same cycle: r_pulse asserted, p_pulse masked for that cycle, and the P press is not retried.
REQ-024 Count prescaler: a counter 0..CNT_DIV-1, wrapping to 0; cnt_tick=1 in the cycle the counter equals CNT_DIV-1.
REQ-025 The count prescaler SHALL be cleared to 0 in the cycle after r_pulse or p_pulse, so the first tick after start occurs a full CNT_DIV cycles later.
REQ-026 Display prescaler: a free-running counter 0..DISP_DIV-1 with disp_tick at terminal count, never cleared by button events.
REQ-027 disp_sel SHALL increment modulo 4 on each disp_tick (3 wraps to 0).
REQ-028 All outputs SHALL be registered, with no combinational path from raw inputs to outputs.

Reset
REQ-029 While rst=1 at a clock edge: synchronizers, stability counters, and prescalers go to 0; FSMs go to IDLE; disp_sel=0; all pulse, tick, and level outputs are 0.
REQ-030 Reset asserted mid-debounce or mid-press SHALL abort without emitting a pulse; a button still held after reset is accepted as a new press after REQ-021 latency.

Structure
REQ-031 Shared package stopwatch_pkg SHALL hold the debounce state enum (IDLE, ARM, HELD, REL) and the default DB_CYCLES, CNT_DIV, and DISP_DIV constants.
REQ-032 Sub-module btn_debounce (synchronizer + FSM + counter, outputs pulse and level) SHALL be instantiated twice; prescalers and the scan counter stay in the top module.

Verification (DB_CYCLES=4, CNT_DIV=10, DISP_DIV=5)
REQ-033 Clean press: btn_p_raw 0->1 first sampled at edge 10, held 50 cycles -> single p_pulse in the cycle after edge 16, r_pulse=0.
REQ-034 Bounce: btn_r_raw toggling every 2 cycles for 20 cycles, then steady 1 -> exactly one r_pulse, 7 cycles after steady begins; r_level rises with it.
REQ-035 Release glitch: R held, then low for 3 cycles, then high again -> r_level stays 1, no second r_pulse; a final 10-cycle low drops r_level.
REQ-036 Ticks: after rst release with no buttons -> cnt_tick every 10 cycles, disp_tick every 5 cycles, disp_sel sequence 0,1,2,3,0.
REQ-037 Prescaler restart and priority: R and P accepted in the same cycle -> r_pulse only, no p_pulse; next cnt_tick exactly 10 cycles after prescaler clear.
REQ-038 Reset mid-ARM: rst asserted 2 cycles into ARM with P held -> no p_pulse; after rst deasserts, p_pulse arrives 7 cycles later.
